mbinit_sb_tx_arbiter: RTL and testbench

- Shares the single sideband TX path between two MBINIT sub-state requesters: the Module (initiator) FSM and the ModulePartner (responder) FSM.
- Each requester posts a message with a one-cycle valid pulse. The arbiter buffers it, waits for the sideband to go idle and grants round-robin.
- It issues the message, tracks which requester owns the in-flight message, and routes the busy falling-edge (completion) back to that owner only.
- Sits between the MBINIT sub-state FSMs (REPAIRCLK/REPAIRVAL/…) and the sideband TX wrapper.

---
 rtl/mbinit_sb_pkg.sv | 27 ++
 rtl/sb_req_slot.sv | 67 ++++++
 rtl/mbinit_sb_tx_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_mbinit_sb_tx_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mbinit_sb_pkg.sv
// Purpose: shared types and message encodings for the MBINIT sideband TX arbiter.
// Latency: n/a (package).
// Backpressure: n/a (package).
package mbinit_sb_pkg;

    // Sideband message encodings used by the MBINIT sub-state FSMs
    localparam logic [3:0] MSG_NONE        = 4'h0;
    localparam logic [3:0] MSG_INIT_REQ    = 4'h1;
    localparam logic [3:0] MSG_INIT_RESP   = 4'h2;
    localparam logic [3:0] MSG_RESULT_REQ  = 4'h3;
    localparam logic [3:0] MSG_RESULT_RESP = 4'h4;
    localparam logic [3:0] MSG_DONE_REQ    = 4'h5;
    localparam logic [3:0] MSG_DONE_RESP   = 4'h6;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_e;

    typedef enum logic {
        MOD = 1'b0,
        PTN = 1'b1
    } owner_e;

endpackage

// File: rtl/sb_req_slot.sv
// Purpose: one-deep request holding register (msg, optional info, full flag).
// Latency: a load is visible as full/msg in the cycle after the valid pulse.
// Backpressure: none; a valid into a full slot is dropped and flagged via o_overflow.
//
// Ports: CLK, rst (sync, active-high), i_enable (low flushes the slot and drops loads),
//        i_load/i_msg/i_info (request), i_clear (slot granted this cycle),
//        o_msg/o_info/o_full (slot contents), o_overflow (one-cycle drop indication).
// Optional: SB_MSG_INFO_EN adds info storage; otherwise o_info is tied to 0.
module sb_req_slot #(
    parameter int MSG_W  = 4,
    parameter int INFO_W = 16
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              i_enable,
    input  logic              i_load,
    input  logic [MSG_W-1:0]  i_msg,
    input  logic [INFO_W-1:0] i_info,
    input  logic              i_clear,
    output logic [MSG_W-1:0]  o_msg,
    output logic [INFO_W-1:0] o_info,
    output logic              o_full,
    output logic              o_overflow
);

    logic             full_q;
    logic [MSG_W-1:0] msg_q;
    // A load in the same cycle as the grant refills the slot instead of overflowing.
    logic             load_ok;

    assign load_ok = i_enable && i_load && (!full_q || i_clear);

    always_ff @(posedge CLK) begin
        if (rst) begin
            full_q <= 1'b0;
            msg_q  <= '0;
        end else if (!i_enable) begin
            full_q <= 1'b0;
        end else if (load_ok) begin
            full_q <= 1'b1;
            msg_q  <= i_msg;
        end else if (i_clear) begin
            full_q <= 1'b0;
        end
    end

`ifdef SB_MSG_INFO_EN
    logic [INFO_W-1:0] info_q;
    always_ff @(posedge CLK) begin
        if (rst) begin
            info_q <= '0;
        end else if (load_ok) begin
            info_q <= i_info;
        end
    end
    assign o_info = info_q;
`else
    logic unused_info;
    assign unused_info = ^i_info;
    assign o_info      = '0;
`endif

    assign o_msg      = msg_q;
    assign o_full     = full_q;
    assign o_overflow = i_enable && i_load && full_q && !i_clear;

endmodule

// File: rtl/mbinit_sb_tx_arbiter.sv
// Purpose: round-robin sharing of the sideband TX path between Module and Partner MBINIT FSMs.
// Latency: valid pulse -> o_TX_valid in 2 cycles when idle; done pulse -> next issue 2 cycles min.
// Backpressure: grants only while i_Busy_SideBand is low; one-deep slot per requester, overflow sticky.
//
// Ports: CLK, rst (sync, active-high), i_enable (low flushes), i_mod_*/i_ptn_* (requests),
//        i_Busy_SideBand, o_TX_SbMessage/o_TX_MsgInfo/o_TX_valid (issue), o_mod_done/o_ptn_done,
//        o_mod_pending/o_ptn_pending, o_overflow/o_timeout (sticky until rst).
// Optional: SB_MSG_INFO_EN enables MsgInfo storage; otherwise o_TX_MsgInfo is tied to 0.
module mbinit_sb_tx_arbiter
    import mbinit_sb_pkg::*;
#(
    parameter int MSG_W        = 4,
    parameter int INFO_W       = 16,
    parameter int BUSY_TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              i_enable,
    input  logic              i_mod_valid,
    input  logic [MSG_W-1:0]  i_mod_msg,
    input  logic [INFO_W-1:0] i_mod_info,
    input  logic              i_ptn_valid,
    input  logic [MSG_W-1:0]  i_ptn_msg,
    input  logic [INFO_W-1:0] i_ptn_info,
    input  logic              i_Busy_SideBand,
    output logic [MSG_W-1:0]  o_TX_SbMessage,
    output logic [INFO_W-1:0] o_TX_MsgInfo,
    output logic              o_TX_valid,
    output logic              o_mod_done,
    output logic              o_ptn_done,
    output logic              o_mod_pending,
    output logic              o_ptn_pending,
    output logic              o_overflow,
    output logic              o_timeout
);

    localparam int                CNT_W   = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(BUSY_TIMEOUT);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, pick;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rr_ptn_q;   // 1: Partner wins the next contended grant
    logic              busy_q, fall;
    logic [MSG_W-1:0]  tx_msg_q;
    logic              overflow_q, timeout_q;

    logic              mod_full, ptn_full, mod_ovf, ptn_ovf, mod_clr, ptn_clr;
    logic [MSG_W-1:0]  mod_msg, ptn_msg;
    logic [INFO_W-1:0] mod_info, ptn_info;
    logic              grant, contend, tx_valid, mod_done, ptn_done, timeout_set;

    sb_req_slot #(.MSG_W(MSG_W), .INFO_W(INFO_W)) u_mod_slot (
        .CLK        (CLK),
        .rst        (rst),
        .i_enable   (i_enable),
        .i_load     (i_mod_valid),
        .i_msg      (i_mod_msg),
        .i_info     (i_mod_info),
        .i_clear    (mod_clr),
        .o_msg      (mod_msg),
        .o_info     (mod_info),
        .o_full     (mod_full),
        .o_overflow (mod_ovf)
    );

    sb_req_slot #(.MSG_W(MSG_W), .INFO_W(INFO_W)) u_ptn_slot (
        .CLK        (CLK),
        .rst        (rst),
        .i_enable   (i_enable),
        .i_load     (i_ptn_valid),
        .i_msg      (i_ptn_msg),
        .i_info     (i_ptn_info),
        .i_clear    (ptn_clr),
        .o_msg      (ptn_msg),
        .o_info     (ptn_info),
        .o_full     (ptn_full),
        .o_overflow (ptn_ovf)
    );

    assign fall    = busy_q && !i_Busy_SideBand;
    assign contend = mod_full && ptn_full;
    assign pick    = contend ? (rr_ptn_q ? PTN : MOD) : (ptn_full ? PTN : MOD);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant       = 1'b0;
        mod_clr     = 1'b0;
        ptn_clr     = 1'b0;
        tx_valid    = 1'b0;
        mod_done    = 1'b0;
        ptn_done    = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            IDLE: begin
                if ((mod_full || ptn_full) && !i_Busy_SideBand) begin
                    grant   = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                tx_valid = 1'b1;
                mod_clr  = (owner_q == MOD);
                ptn_clr  = (owner_q == PTN);
                cnt_d    = '0;
                state_d  = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (i_Busy_SideBand) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == CNT_MAX) begin
                    // Lost message: release the owner so its FSM can retry or escalate.
                    timeout_set = 1'b1;
                    mod_done    = (owner_q == MOD);
                    ptn_done    = (owner_q == PTN);
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (fall) begin
                    mod_done = (owner_q == MOD);
                    ptn_done = (owner_q == PTN);
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Disable wins over everything; the strobe is also held off so no
        // message leaves whose completion would never be reported.
        if (!i_enable) begin
            state_d     = IDLE;
            cnt_d       = '0;
            grant       = 1'b0;
            tx_valid    = 1'b0;
            mod_done    = 1'b0;
            ptn_done    = 1'b0;
            timeout_set = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            owner_q    <= PTN;
            rr_ptn_q   <= 1'b1;
            busy_q     <= 1'b0;
            tx_msg_q   <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_q     <= i_Busy_SideBand;
            overflow_q <= overflow_q | mod_ovf | ptn_ovf;
            timeout_q  <= timeout_q | timeout_set;
            if (grant) begin
                owner_q  <= pick;
                tx_msg_q <= (pick == PTN) ? ptn_msg : mod_msg;
                // The pointer only moves when it actually arbitrated.
                if (contend) begin
                    rr_ptn_q <= !rr_ptn_q;
                end
            end
        end
    end

`ifdef SB_MSG_INFO_EN
    logic [INFO_W-1:0] tx_info_q;
    always_ff @(posedge CLK) begin
        if (rst) begin
            tx_info_q <= '0;
        end else if (grant) begin
            tx_info_q <= (pick == PTN) ? ptn_info : mod_info;
        end
    end
    assign o_TX_MsgInfo = tx_info_q;
`else
    logic unused_info;
    assign unused_info  = ^{mod_info, ptn_info};
    assign o_TX_MsgInfo = '0;
`endif

    assign o_TX_SbMessage = tx_msg_q;
    assign o_TX_valid     = tx_valid;
    assign o_mod_done     = mod_done;
    assign o_ptn_done     = ptn_done;
    assign o_mod_pending  = mod_full || ((state_q != IDLE) && (owner_q == MOD));
    assign o_ptn_pending  = ptn_full || ((state_q != IDLE) && (owner_q == PTN));
    assign o_overflow     = overflow_q;
    assign o_timeout      = timeout_q;

endmodule

// File: tb/tb_mbinit_sb_tx_arbiter.sv
// Purpose: directed self-checking bench for mbinit_sb_tx_arbiter (BUSY_TIMEOUT=8).
// Latency: inputs driven 1 time unit after posedge, outputs sampled at negedge.
// Backpressure: i_Busy_SideBand driven directly by the directed steps.
module tb_mbinit_sb_tx_arbiter;

    logic        CLK = 1'b0;
    logic        rst;
    logic        i_enable;
    logic        i_mod_valid, i_ptn_valid;
    logic [3:0]  i_mod_msg, i_ptn_msg;
    logic [15:0] i_mod_info, i_ptn_info;
    logic        i_Busy_SideBand;
    logic [3:0]  o_TX_SbMessage;
    logic [15:0] o_TX_MsgInfo;
    logic        o_TX_valid, o_mod_done, o_ptn_done;
    logic        o_mod_pending, o_ptn_pending, o_overflow, o_timeout;

    int checks   = 0;
    int failures = 0;

`ifdef SB_MSG_INFO_EN
    localparam bit INFO_EN = 1'b1;
`else
    localparam bit INFO_EN = 1'b0;
`endif

    mbinit_sb_tx_arbiter #(.MSG_W(4), .INFO_W(16), .BUSY_TIMEOUT(8)) dut (
        .CLK             (CLK),
        .rst             (rst),
        .i_enable        (i_enable),
        .i_mod_valid     (i_mod_valid),
        .i_mod_msg       (i_mod_msg),
        .i_mod_info      (i_mod_info),
        .i_ptn_valid     (i_ptn_valid),
        .i_ptn_msg       (i_ptn_msg),
        .i_ptn_info      (i_ptn_info),
        .i_Busy_SideBand (i_Busy_SideBand),
        .o_TX_SbMessage  (o_TX_SbMessage),
        .o_TX_MsgInfo    (o_TX_MsgInfo),
        .o_TX_valid      (o_TX_valid),
        .o_mod_done      (o_mod_done),
        .o_ptn_done      (o_ptn_done),
        .o_mod_pending   (o_mod_pending),
        .o_ptn_pending   (o_ptn_pending),
        .o_overflow      (o_overflow),
        .o_timeout       (o_timeout)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Start of a cycle: valid pulses are one cycle wide, so they drop here.
    task automatic cyc();
        @(posedge CLK);
        #1;
        i_mod_valid = 1'b0;
        i_ptn_valid = 1'b0;
    endtask

    task automatic smp();
        @(negedge CLK);
    endtask

    // From ISSUE: one WAIT_BUSY cycle with busy rising, then busy falls in WAIT_DONE.
    task automatic serve(input string tag, input logic exp_mod, input logic exp_ptn);
        cyc(); i_Busy_SideBand = 1'b1;
        cyc(); i_Busy_SideBand = 1'b0;
        smp();
        chk({tag, "_mod_done"}, {31'd0, o_mod_done}, {31'd0, exp_mod});
        chk({tag, "_ptn_done"}, {31'd0, o_ptn_done}, {31'd0, exp_ptn});
    endtask

    initial begin
        rst = 1'b1; i_enable = 1'b1; i_Busy_SideBand = 1'b0;
        i_mod_valid = 1'b0; i_ptn_valid = 1'b0;
        i_mod_msg = 4'h0; i_ptn_msg = 4'h0; i_mod_info = 16'h0; i_ptn_info = 16'h0;

        // Reset state
        cyc(); cyc(); smp();
        chk("rst_valid_done", {29'd0, o_TX_valid, o_mod_done, o_ptn_done}, 32'd0);
        chk("rst_msg_info", {12'd0, o_TX_SbMessage, o_TX_MsgInfo}, 32'd0);
        chk("rst_flags", {28'd0, o_mod_pending, o_ptn_pending, o_overflow, o_timeout}, 32'd0);

        // Single Partner request
        cyc(); rst = 1'b0; i_ptn_valid = 1'b1; i_ptn_msg = 4'b0010; i_ptn_info = 16'hA5A5;
        smp(); chk("single_c0_valid", {31'd0, o_TX_valid}, 32'd0);
        cyc(); smp();
        chk("single_c1_valid", {31'd0, o_TX_valid}, 32'd0);
        chk("single_c1_pend", {31'd0, o_ptn_pending}, 32'd1);
        cyc(); smp();
        chk("single_issue_valid", {31'd0, o_TX_valid}, 32'd1);
        chk("single_issue_msg", {28'd0, o_TX_SbMessage}, 32'h2);
        chk("single_issue_info", {16'd0, o_TX_MsgInfo}, INFO_EN ? 32'hA5A5 : 32'h0);
        cyc(); smp();
        chk("single_strobe_off", {31'd0, o_TX_valid}, 32'd0);
        chk("single_msg_hold", {28'd0, o_TX_SbMessage}, 32'h2);
        chk("single_inflight_pend", {30'd0, o_mod_pending, o_ptn_pending}, 32'b01);
        cyc(); i_Busy_SideBand = 1'b1;
        smp(); chk("single_busy1_done", {30'd0, o_mod_done, o_ptn_done}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(); smp();
            chk("single_busy_done", {30'd0, o_mod_done, o_ptn_done}, 32'd0);
        end
        cyc(); i_Busy_SideBand = 1'b0;
        smp(); chk("single_fall_done", {30'd0, o_mod_done, o_ptn_done}, 32'b01);
        cyc(); smp();
        chk("single_after_done", {29'd0, o_ptn_done, o_ptn_pending, o_TX_valid}, 32'd0);

        // Contention: Partner first, then Module; next pair goes Module first
        cyc(); i_mod_valid = 1'b1; i_mod_msg = 4'b0001; i_ptn_valid = 1'b1; i_ptn_msg = 4'b0010;
        cyc(); smp();
        chk("cont_both_pend", {30'd0, o_mod_pending, o_ptn_pending}, 32'b11);
        cyc(); smp();
        chk("cont1_issue", {27'd0, o_TX_valid, o_TX_SbMessage}, {27'd0, 1'b1, 4'b0010});
        serve("cont1", 1'b0, 1'b1);
        cyc(); smp(); chk("cont2_gap", {31'd0, o_TX_valid}, 32'd0);
        cyc(); smp();
        chk("cont2_issue", {27'd0, o_TX_valid, o_TX_SbMessage}, {27'd0, 1'b1, 4'b0001});
        serve("cont2", 1'b1, 1'b0);
        cyc(); i_mod_valid = 1'b1; i_mod_msg = 4'b0011; i_ptn_valid = 1'b1; i_ptn_msg = 4'b0100;
        cyc(); cyc(); smp();
        chk("cont3_issue", {27'd0, o_TX_valid, o_TX_SbMessage}, {27'd0, 1'b1, 4'b0011});
        serve("cont3", 1'b1, 1'b0);
        cyc(); cyc(); smp();
        chk("cont4_issue", {27'd0, o_TX_valid, o_TX_SbMessage}, {27'd0, 1'b1, 4'b0100});
        serve("cont4", 1'b0, 1'b1);

        // Overflow while sideband is busy
        cyc(); i_Busy_SideBand = 1'b1; i_mod_valid = 1'b1; i_mod_msg = 4'b0101;
        smp(); chk("ovf_first", {31'd0, o_overflow}, 32'd0);
        cyc(); i_mod_valid = 1'b1; i_mod_msg = 4'b0110;
        smp(); chk("ovf_blocked", {30'd0, o_TX_valid, o_overflow}, 32'd0);
        cyc(); smp();
        chk("ovf_set", {29'd0, o_overflow, o_mod_pending, o_TX_valid}, 32'b110);
        cyc(); i_Busy_SideBand = 1'b0;
        smp(); chk("ovf_nogrant", {31'd0, o_TX_valid}, 32'd0);
        cyc(); smp();
        chk("ovf_issue", {27'd0, o_TX_valid, o_TX_SbMessage}, {27'd0, 1'b1, 4'b0101});
        serve("ovf", 1'b1, 1'b0);
        cyc(); smp(); chk("ovf_sticky", {31'd0, o_overflow}, 32'd1);

        // Timeout: busy never rises
        cyc(); i_ptn_valid = 1'b1; i_ptn_msg = 4'b0111;
        cyc(); cyc(); smp();
        chk("to_issue", {27'd0, o_TX_valid, o_TX_SbMessage}, {27'd0, 1'b1, 4'b0111});
        for (int i = 0; i < 8; i++) begin
            cyc(); smp();
            chk("to_wait", {29'd0, o_ptn_done, o_mod_done, o_timeout}, 32'd0);
        end
        cyc(); smp();
        chk("to_done", {30'd0, o_mod_done, o_ptn_done}, 32'b01);
        cyc(); smp();
        chk("to_sticky", {28'd0, o_timeout, o_ptn_done, o_ptn_pending, o_TX_valid}, 32'b1000);

        // Flush during WAIT_DONE with a Module slot full
        cyc(); i_ptn_valid = 1'b1; i_ptn_msg = 4'b1000;
        cyc(); cyc(); smp();
        chk("fl_issue", {27'd0, o_TX_valid, o_TX_SbMessage}, {27'd0, 1'b1, 4'b1000});
        cyc(); i_Busy_SideBand = 1'b1; i_mod_valid = 1'b1; i_mod_msg = 4'b1001;
        cyc(); smp();
        chk("fl_pend", {30'd0, o_mod_pending, o_ptn_pending}, 32'b11);
        cyc(); i_enable = 1'b0;
        smp(); chk("fl_dis_done", {30'd0, o_mod_done, o_ptn_done}, 32'd0);
        cyc(); i_enable = 1'b1;
        smp(); chk("fl_pend_clr", {30'd0, o_mod_pending, o_ptn_pending}, 32'd0);
        cyc(); i_Busy_SideBand = 1'b0;
        smp(); chk("fl_fall_done", {30'd0, o_mod_done, o_ptn_done}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc(); smp();
            chk("fl_no_issue", {31'd0, o_TX_valid}, 32'd0);
        end

        // Reset in ISSUE restores Partner priority
        cyc(); i_mod_valid = 1'b1; i_mod_msg = 4'b1010; i_ptn_valid = 1'b1; i_ptn_msg = 4'b1011;
        cyc(); cyc(); rst = 1'b1;
        smp();
        chk("rs_issue", {27'd0, o_TX_valid, o_TX_SbMessage}, {27'd0, 1'b1, 4'b1011});
        cyc(); rst = 1'b0;
        smp();
        chk("rs_outs", {12'd0, o_TX_SbMessage, o_TX_MsgInfo}, 32'd0);
        chk("rs_flags", {25'd0, o_TX_valid, o_mod_done, o_ptn_done, o_mod_pending,
                         o_ptn_pending, o_overflow, o_timeout}, 32'd0);
        cyc(); i_mod_valid = 1'b1; i_mod_msg = 4'b1100; i_ptn_valid = 1'b1; i_ptn_msg = 4'b1101;
        cyc(); cyc(); smp();
        chk("rs_prio", {27'd0, o_TX_valid, o_TX_SbMessage}, {27'd0, 1'b1, 4'b1101});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
